mem_loader: RTL
===============

Name: mem_loader

Overview:
- Writable counterpart to the team's preloaded weight/bias/data ROMs.
- Accepts a byte stream, packs BYTES_PER_WORD bytes into one wide word and writes it to an internal array at an auto-incrementing address.
- Exposes the same addr/mem_read read interface the MLP controller already uses, so it can replace a preloaded memory without a simulation-time file load.

Parameters:
- BYTES_PER_WORD, 62, bytes packed per memory word; word width = 8*BYTES_PER_WORD.
- DEPTH, 750, number of words; one load fills addresses 0..DEPTH-1.
- ADDR_W, 10, address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a load; sampled only in IDLE
- in_valid  input  1  byte present on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- busy  output  1  load in progress
- done  output  1  load completed; level signal
- words_written  output  ADDR_W+1  words committed in the current/last load
- checksum_err  output  1  trailer mismatch (see Optional Feature)
- addr  input  ADDR_W  read address
- mem_read  input  1  read enable
- rd_data  output  8*BYTES_PER_WORD  read data

Behaviour:
- Reset:
  - state=IDLE, in_ready=0, busy=0, done=0, words_written=0, checksum_err=0, rd_data=0.
  - Internal byte counter, write address and pack register are cleared.
  - Array contents are not cleared.
- Handshake: a byte transfers on a cycle with in_valid=1 and in_ready=1. in_ready depends only on state (=1 only in FILL), never on in_valid.
- States:
  - IDLE: start=1 -> FILL. On that edge: done<=0, checksum_err<=0, words_written<=0, wr_addr<=0, byte_cnt<=0.
  - FILL: each accepted byte goes to pack slot byte_cnt, then byte_cnt++. The first byte of a word occupies bits [8*BPW-1 -: 8]; the last occupies [7:0], matching hex-file text order. Accepting byte BPW-1 -> WRITE with byte_cnt<=0.
  - WRITE: one cycle, in_ready=0. mem[wr_addr]<=pack, wr_addr++, words_written++. If wr_addr==DEPTH-1 -> DONE (or CHECK with the macro), else -> FILL.
  - DONE: done=1, busy=0. start=1 -> FILL with the same clears as IDLE.
- busy=1 in FILL, WRITE and CHECK.
- start is ignored while busy.
- in_valid outside FILL is ignored and the byte is not consumed.
- Throughput: at most one word per BPW+1 cycles.
- Read port:
  - mem_read=1 -> rd_data<=mem[addr] on the next edge (1-cycle latency).
  - mem_read=0 -> rd_data holds.
  - Read is allowed in any state. Reading the address written in the same cycle returns the old contents.
  - addr>=DEPTH -> rd_data<=0.
- Reset mid-load: returns to IDLE next edge. Words already committed keep their values; the partial pack is discarded.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit running sum (mod 256) accumulates every data byte of the load.
  - After the final WRITE the FSM enters CHECK with in_ready=1 and accepts one trailer byte.
  - checksum_err<=(sum+trailer)!=8'h00, then -> DONE.
  - The sum clears on start.
- Disabled: no CHECK state, WRITE of the last word goes directly to DONE, checksum_err is constant 0.

Test Plan:
- BPW=4, DEPTH=3:
  - Stream bytes 01..0C with in_valid held high -> mem[0]=32'h01020304, mem[1]=32'h05060708, mem[2]=32'h090A0B0C.
  - words_written=3, done=1, busy=0; load takes exactly 15 cycles after start.
- Backpressure: toggle in_valid randomly through the same stream -> identical contents. in_ready is low in each WRITE cycle and the byte offered then is accepted on the next FILL cycle.
- Read port: mem_read=1, addr=1 -> rd_data=32'h05060708 one cycle later. Drop mem_read and change addr -> rd_data holds. addr=5 -> rd_data=0.
- Reset mid-load: assert rst after byte 06 -> IDLE, busy=0, words_written=0, mem[0] still 32'h01020304. New start then reloads correctly from address 0.
- start pulsed in FILL -> ignored, no counter clear. start in DONE -> done drops the next cycle, new load begins.
- LOADER_CHECKSUM_EN, bytes 01..0C, data sum 8'h4E:
  - trailer 8'hB2 -> checksum_err=0.
  - trailer 8'hB3 -> checksum_err=1.
  - done asserts only after the trailer is accepted.

Source files
------------

// File: rtl/mem_loader.sv
// mem_loader: byte-stream loader for a wide-word memory.
// Bytes from a valid/ready stream are packed BYTES_PER_WORD at a time and
// written to consecutive addresses 0..DEPTH-1. Reads use the same addr/mem_read
// port as the preloaded ROMs, with one cycle of latency.
// Optional build macro LOADER_CHECKSUM_EN adds a trailer byte after the last
// word. The load fails the check if the trailer plus the 8-bit data sum is not zero.
module mem_loader #(
  parameter int BYTES_PER_WORD = 62,
  parameter int DEPTH          = 750,
  parameter int ADDR_W         = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_W:0]             words_written,
  output logic                        checksum_err,
  input  logic [ADDR_W-1:0]           addr,
  input  logic                        mem_read,
  output logic [8*BYTES_PER_WORD-1:0] rd_data
);

  localparam int W     = 8 * BYTES_PER_WORD;
  localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic                 in_ready_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 in_ready_s;
  logic                 busy_s;
  logic                 done_s;
  logic                 accept_s;
  logic [CNT_W-1:0]     byte_cnt_r;
  logic [ADDR_W-1:0]    wr_addr_r;
  logic [W-1:0]         pack_r;
  logic [ADDR_W:0]      words_written_r;
  logic [W-1:0]         rd_data_r;
  logic                 rd_in_range_s;
  logic [IDX_W-1:0]     rd_idx_s;
  logic [IDX_W-1:0]     wr_idx_s;
  logic [W-1:0]         mem [0:DEPTH-1];

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           sum_r;
  logic                 checksum_err_r;

  // A load is bad when data sum plus trailer does not wrap to zero.
  function automatic logic checksum_bad(input logic [7:0] sum, input logic [7:0] trailer);
    logic [7:0] total;
    total = sum + trailer;
    return (total != 8'h00);
  endfunction
`endif

  // A byte moves only when the loader is ready; ready is a pure state decode.
  assign accept_s      = in_valid & in_ready_r;
  assign rd_in_range_s = ({1'b0, addr} < DEPTH_W);
  assign rd_idx_s      = IDX_W'(addr);
  assign wr_idx_s      = IDX_W'(wr_addr_r);

  // Next-state decode plus the next value of the state-derived outputs.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_FILL;
        else       state_s = ST_IDLE;
      end
      ST_FILL: begin
        if (accept_s && (byte_cnt_r == LAST_BYTE)) state_s = ST_WRITE;
        else                                       state_s = ST_FILL;
      end
      ST_WRITE: begin
        if (wr_addr_r == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
          state_s = ST_CHECK;
`else
          state_s = ST_DONE;
`endif
        end else begin
          state_s = ST_FILL;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_s) state_s = ST_DONE;
        else          state_s = ST_CHECK;
      end
`endif
      ST_DONE: begin
        if (start) state_s = ST_FILL;
        else       state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase

    in_ready_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    case (state_s)
      ST_FILL: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
      ST_WRITE: busy_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
`endif
      ST_DONE: done_s = 1'b1;
      default: begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
      end
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  // Byte packing, write address and word counting for the active load.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_r      <= '0;
      wr_addr_r       <= '0;
      pack_r          <= '0;
      words_written_r <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_r           <= 8'h00;
      checksum_err_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            byte_cnt_r      <= '0;
            wr_addr_r       <= '0;
            pack_r          <= '0;
            words_written_r <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_r           <= 8'h00;
            checksum_err_r  <= 1'b0;
`endif
          end
        end
        ST_FILL: begin
          if (accept_s) begin
            // Shifting in from the bottom leaves the first byte in the top slot.
            pack_r <= {pack_r[W-9:0], in_data};
            if (byte_cnt_r == LAST_BYTE) byte_cnt_r <= '0;
            else                         byte_cnt_r <= byte_cnt_r + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
            sum_r <= sum_r + in_data;
`endif
          end
        end
        ST_WRITE: begin
          wr_addr_r       <= wr_addr_r + ADDR_W'(1);
          words_written_r <= words_written_r + (ADDR_W + 1)'(1);
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept_s) checksum_err_r <= checksum_bad(sum_r, in_data);
        end
`endif
        default: begin
          byte_cnt_r <= byte_cnt_r;
        end
      endcase
    end
  end

  // Word commit; the array itself is never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == ST_WRITE)) begin
      mem[wr_idx_s] <= pack_r;
    end
  end

  // Read port with one cycle of latency; out-of-range addresses read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= '0;
    end else if (mem_read) begin
      if (rd_in_range_s) rd_data_r <= mem[rd_idx_s];
      else               rd_data_r <= '0;
    end
  end

  assign in_ready      = in_ready_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign words_written = words_written_r;
  assign rd_data       = rd_data_r;
`ifdef LOADER_CHECKSUM_EN
  assign checksum_err  = checksum_err_r;
`else
  assign checksum_err  = 1'b0;
`endif

endmodule
